// File: rtl/rf_pkg.sv
// rf_pkg: shared address-width helper and default-config per-port typedefs for the register file.
package rf_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int NWR_DEF = 2;
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int AW_DEF = addr_w(NREGS_DEF);
  typedef logic [AW_DEF-1:0] addr_t;
  typedef logic [XLEN_DEF-1:0] data_t;
  typedef addr_t [NRD_DEF-1:0] rd_addr_vec_t;
  typedef data_t [NRD_DEF-1:0] rd_data_vec_t;
  typedef addr_t [NWR_DEF-1:0] wr_addr_vec_t;
  typedef data_t [NWR_DEF-1:0] wr_data_vec_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with issue-set / write-clear resolution and a registered population count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = addr_w(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0]          rd_busy,
  output logic [AW:0]             busy_cnt
);
  logic [NREGS-1:0] busy, set, clr, busy_next, busy_view;
  logic [AW:0] pop;
  always_comb begin
    set = '0;
    clr = '0;
    set[iss_addr] = iss_en && (iss_addr != '0);
    for (int i = 0; i < NWR; i++)
      if (wr_en[i]) clr[wr_addr[i]] = 1'b1;
    busy_next = (busy & ~clr) | set;
    busy_next[0] = 1'b0;
    pop = '0;
    for (int j = 0; j < NREGS; j++)
      pop = pop + (AW+1)'(busy_next[j]);
  end
  // Forwarding only hides a clear in flight; a fresh issue shows up after the edge.
  assign busy_view = (BYPASS != 0) ? (busy & ~(clr & ~set)) : busy;
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++)
      rd_busy[k] = busy_view[rd_addr[k]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_next;
      busy_cnt <= pop;
    end
  end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with x0 hardwired to zero, optional write bypass and a busy scoreboard.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = addr_w(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [AW:0]              busy_cnt
);
  logic [XLEN-1:0] regs [NREGS];
  // Later ports are visited last, so the highest-index writer wins on a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i] != '0) regs[wr_addr[i]] <= wr_data[i];
    end
  end
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k] = (rd_addr[k] == '0) ? '0 : regs[rd_addr[k]];
      for (int i = 0; i < NWR; i++)
        if (BYPASS != 0 && wr_en[i] && wr_addr[i] != '0 && wr_addr[i] == rd_addr[k])
          rd_data[k] = wr_data[i];
    end
  end
  rf_scoreboard #(
    .NREGS(NREGS),
    .NRD(NRD),
    .NWR(NWR),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .busy_cnt(busy_cnt)
  );
endmodule
